// File: rtl/loop_pkg.sv
// Shared types for the drum loop recorder: FSM state encoding and the stored event record.
package loop_pkg;
  localparam int N_VOICES = 5;
  localparam int TS_W     = 16;

  typedef enum logic [1:0] {IDLE = 2'd0, REC = 2'd1, PLAY = 2'd2} state_t;

  typedef struct packed {
    logic [TS_W-1:0]     ts;
    logic [N_VOICES-1:0] mask;
  } event_t;
endpackage

// File: rtl/loop_recorder_if.sv
// Control/trigger bundle between the pad front end, the loop recorder and the voice mux.
interface loop_recorder_if
  import loop_pkg::*;
#(
  parameter int CNT_W = 9
) ();
  logic                sample_tick;
  logic                rec_start;
  logic                rec_stop;
  logic                play_start;
  logic                play_stop;
  logic [N_VOICES-1:0] hit;
  logic [N_VOICES-1:0] play_hit;
  logic                rec_active;
  logic                play_active;
  logic                rec_done;
  logic                overflow;
  logic [CNT_W-1:0]    event_count;

  modport master (
    output sample_tick, rec_start, rec_stop, play_start, play_stop, hit,
    input  play_hit, rec_active, play_active, rec_done, overflow, event_count
  );
  modport slave (
    input  sample_tick, rec_start, rec_stop, play_start, play_stop, hit,
    output play_hit, rec_active, play_active, rec_done, overflow, event_count
  );
endinterface

// File: rtl/loop_event_ram.sv
// Single-port synchronous event store, one-clock read latency (block-RAM friendly, no reset).
module loop_event_ram #(
  parameter int DEPTH = 256,
  parameter int W     = 21
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic                     re,
  input  logic [$clog2(DEPTH)-1:0] addr,
  input  logic [W-1:0]             wdata,
  output logic [W-1:0]             rdata
);
  logic [W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we)      mem[addr] <= wdata;
    else if (re) rdata     <= mem[addr];
  end
endmodule

// File: rtl/loop_recorder.sv
// Event-based drum loop recorder/player. Define LOOP_QUANTIZE_EN to floor stored
// timestamps to a 2**QUANT_SHIFT tick grid; otherwise raw timestamps are stored.
module loop_recorder
  import loop_pkg::*;
#(
  parameter int DEPTH       = 256,
  parameter int QUANT_SHIFT = 9
) (
  input  logic            clk,
  input  logic            rst_n,
  loop_recorder_if.slave  bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [1:0] ST_IDLE = 2'(IDLE);
  localparam logic [1:0] ST_REC  = 2'(REC);
  localparam logic [1:0] ST_PLAY = 2'(PLAY);
  localparam logic [TS_W-1:0] TS_MAX = '1;
  localparam logic [TS_W-1:0] Q_MASK = {TS_W{1'b1}} << QUANT_SHIFT;
`ifdef LOOP_QUANTIZE_EN
  localparam logic QUANT_ON = 1'b1;
`else
  localparam logic QUANT_ON = 1'b0;
`endif

  logic [1:0]          state;
  logic [TS_W-1:0]     ts, loop_len;
  logic [CW-1:0]       count, rd_ptr;
  logic                loop_valid, head_vld, overflow, rec_done;
  logic [N_VOICES-1:0] play_hit;

  logic                in_rec, in_play, full, ram_we, match, wrap, auto_stop;
  logic [AW-1:0]       ram_addr;
  event_t              ram_d, ram_q;

  always_comb begin
    in_rec     = state == ST_REC;
    in_play    = state == ST_PLAY;
    full       = count == CW'(DEPTH);
    ram_we     = in_rec && !bus.rec_start && (|bus.hit) && !full;
    ram_d.ts   = QUANT_ON ? (ts & Q_MASK) : ts;
    ram_d.mask = bus.hit;
    ram_addr   = in_rec ? count[AW-1:0] : rd_ptr[AW-1:0];
    // head is only trusted one clock after rd_ptr settles (RAM read latency)
    match      = in_play && head_vld && (ram_q.ts == ts) && (rd_ptr < count);
    wrap       = bus.sample_tick && (ts == loop_len - 1'b1);
    auto_stop  = bus.sample_tick && (ts == TS_MAX - 1'b1);
  end

  loop_event_ram #(.DEPTH(DEPTH), .W($bits(event_t))) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .re    (in_play),
    .addr  (ram_addr),
    .wdata (ram_d),
    .rdata (ram_q)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      ts         <= '0;
      loop_len   <= '0;
      count      <= '0;
      rd_ptr     <= '0;
      loop_valid <= 1'b0;
      head_vld   <= 1'b0;
      overflow   <= 1'b0;
      rec_done   <= 1'b0;
      play_hit   <= '0;
    end else begin
      rec_done <= 1'b0;
      play_hit <= '0;
      if (bus.rec_start) begin
        // a new take always wins, from any state
        state      <= ST_REC;
        ts         <= '0;
        count      <= '0;
        overflow   <= 1'b0;
        loop_valid <= 1'b0;
      end else begin
        case (state)
          ST_IDLE: begin
            if (bus.play_start && loop_valid) begin
              state    <= ST_PLAY;
              ts       <= '0;
              rd_ptr   <= '0;
              head_vld <= 1'b0;
            end
          end
          ST_REC: begin
            if (ram_we) count <= count + 1'b1;
            if ((|bus.hit) && full) overflow <= 1'b1;
            if (bus.rec_stop || auto_stop) begin
              // ts never reaches TS_MAX here, so ts+1 covers both stop causes
              state      <= ST_IDLE;
              loop_len   <= ts + 1'b1;
              loop_valid <= 1'b1;
              rec_done   <= 1'b1;
            end else if (bus.sample_tick) begin
              ts <= ts + 1'b1;
            end
          end
          ST_PLAY: begin
            if (bus.play_stop) begin
              state <= ST_IDLE;
            end else if (bus.play_start) begin
              ts       <= '0;
              rd_ptr   <= '0;
              head_vld <= 1'b0;
            end else begin
              if (match) play_hit <= ram_q.mask;
              if (wrap) begin
                ts       <= '0;
                rd_ptr   <= '0;
                head_vld <= 1'b0;
              end else begin
                if (bus.sample_tick) ts <= ts + 1'b1;
                if (match) begin
                  rd_ptr   <= rd_ptr + 1'b1;
                  head_vld <= 1'b0;
                end else begin
                  head_vld <= 1'b1;
                end
              end
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

  assign bus.play_hit    = play_hit;
  assign bus.rec_active  = in_rec;
  assign bus.play_active = in_play;
  assign bus.rec_done    = rec_done;
  assign bus.overflow    = overflow;
  assign bus.event_count = count;
endmodule

// File: tb/tb_loop_recorder.sv
// Directed bench for loop_recorder: record/playback timing, wrap, same-tick events,
// overflow on a 4-entry instance, reset behaviour and optional quantisation.
module tb_loop_recorder;
  import loop_pkg::*;

  localparam int TP = 6;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  loop_recorder_if #(.CNT_W(9)) if0 ();
  loop_recorder_if #(.CNT_W(3)) if1 ();

  loop_recorder #(.DEPTH(256), .QUANT_SHIFT(3)) u_dut (
    .clk(clk), .rst_n(rst_n), .bus(if0.slave));
  loop_recorder #(.DEPTH(4), .QUANT_SHIFT(3)) u_small (
    .clk(clk), .rst_n(rst_n), .bus(if1.slave));

  typedef struct {
    int          t;
    logic [4:0]  m;
    int          c;
  } ev_t;

  int   total = 0;
  int   bad = 0;
  int   tcnt = 0;
  int   cycn = 0;
  ev_t  log_q[$];

  function automatic int eq(int t);
`ifdef LOOP_QUANTIZE_EN
    return t & ~7;
`else
    return t;
`endif
  endfunction

  task automatic idle_in();
    if0.sample_tick = 0; if0.rec_start = 0; if0.rec_stop = 0;
    if0.play_start = 0; if0.play_stop = 0; if0.hit = '0;
    if1.sample_tick = 0; if1.rec_start = 0; if1.rec_stop = 0;
    if1.play_start = 0; if1.play_stop = 0; if1.hit = '0;
  endtask

  task automatic cyc();
    ev_t e;
    @(posedge clk);
    #1;
    cycn++;
    if (if0.play_hit != '0) begin
      e.t = tcnt; e.m = if0.play_hit; e.c = cycn;
      log_q.push_back(e);
    end
  endtask

  task automatic ticks(int n);
    for (int i = 0; i < n; i++) begin
      if0.sample_tick = 1; cyc(); if0.sample_tick = 0;
      tcnt++;
      repeat (TP - 1) cyc();
    end
  endtask

  task automatic test_reset();
    idle_in();
    rst_n = 0;
    repeat (3) @(posedge clk);
    #1;
    total++; if (if0.play_hit !== 5'b0) begin bad++; $display("FAIL reset_play_hit got=%b exp=0", if0.play_hit); end
    total++; if (if0.rec_active !== 1'b0) begin bad++; $display("FAIL reset_rec_active got=%b exp=0", if0.rec_active); end
    total++; if (if0.play_active !== 1'b0) begin bad++; $display("FAIL reset_play_active got=%b exp=0", if0.play_active); end
    total++; if (if0.rec_done !== 1'b0) begin bad++; $display("FAIL reset_rec_done got=%b exp=0", if0.rec_done); end
    total++; if (if0.overflow !== 1'b0) begin bad++; $display("FAIL reset_overflow got=%b exp=0", if0.overflow); end
    total++; if (if0.event_count !== 9'd0) begin bad++; $display("FAIL reset_count got=%0d exp=0", if0.event_count); end
    total++; if (if1.event_count !== 3'd0) begin bad++; $display("FAIL reset_small_count got=%0d exp=0", if1.event_count); end
    rst_n = 1;
    cyc();
  endtask

  task automatic test_record();
    if0.rec_start = 1; cyc(); if0.rec_start = 0;
    total++; if (if0.rec_active !== 1'b1) begin bad++; $display("FAIL rec_active got=%b exp=1", if0.rec_active); end
    ticks(10); if0.hit = 5'b00001; cyc(); if0.hit = '0;
    ticks(10); if0.hit = 5'b00100; cyc(); if0.hit = '0;
    ticks(29);
    if0.rec_stop = 1; cyc(); if0.rec_stop = 0;
    total++; if (if0.rec_done !== 1'b1) begin bad++; $display("FAIL rec_done_pulse got=%b exp=1", if0.rec_done); end
    total++; if (if0.rec_active !== 1'b0) begin bad++; $display("FAIL rec_active_after_stop got=%b exp=0", if0.rec_active); end
    total++; if (if0.event_count !== 9'd2) begin bad++; $display("FAIL rec_count got=%0d exp=2", if0.event_count); end
    cyc();
    total++; if (if0.rec_done !== 1'b0) begin bad++; $display("FAIL rec_done_width got=%b exp=0", if0.rec_done); end
  endtask

  task automatic test_play();
    int         rel[5] = '{10, 20, 10, 20, 10};
    int         lp[5]  = '{0, 0, 1, 1, 2};
    logic [4:0] em[5]  = '{5'b00001, 5'b00100, 5'b00001, 5'b00100, 5'b00001};
    int         et;
    log_q.delete(); tcnt = 0;
    if0.play_start = 1; cyc(); if0.play_start = 0;
    total++; if (if0.play_active !== 1'b1) begin bad++; $display("FAIL play_active got=%b exp=1", if0.play_active); end
    ticks(115);
    total++; if (log_q.size() != 5) begin bad++; $display("FAIL play_event_num got=%0d exp=5", log_q.size()); end
    for (int i = 0; i < 5 && i < log_q.size(); i++) begin
      et = eq(rel[i]) + 50 * lp[i];
      total++; if (log_q[i].t != et || log_q[i].m !== em[i]) begin
        bad++; $display("FAIL play_event%0d got tick=%0d mask=%b exp tick=%0d mask=%b", i, log_q[i].t, log_q[i].m, et, em[i]);
      end
    end
    // restart while already playing
    log_q.delete(); tcnt = 0;
    if0.play_start = 1; cyc(); if0.play_start = 0;
    ticks(12);
    total++; if (log_q.size() != 1) begin bad++; $display("FAIL restart_num got=%0d exp=1", log_q.size()); end
    else begin
      total++; if (log_q[0].t != eq(10) || log_q[0].m !== 5'b00001) begin
        bad++; $display("FAIL restart_event got tick=%0d mask=%b exp tick=%0d mask=00001", log_q[0].t, log_q[0].m, eq(10));
      end
    end
    if0.play_stop = 1; cyc(); if0.play_stop = 0;
    total++; if (if0.play_active !== 1'b0) begin bad++; $display("FAIL stop_play_active got=%b exp=0", if0.play_active); end
    total++; if (if0.play_hit !== 5'b0) begin bad++; $display("FAIL stop_play_hit got=%b exp=0", if0.play_hit); end
  endtask

  task automatic test_same_tick();
    if0.rec_start = 1; cyc(); if0.rec_start = 0;
    ticks(5);
    if0.hit = 5'b10010; cyc();
    if0.hit = 5'b00001; cyc();
    if0.hit = '0;
    ticks(3);
    if0.rec_stop = 1; cyc(); if0.rec_stop = 0;
    total++; if (if0.event_count !== 9'd2) begin bad++; $display("FAIL same_tick_count got=%0d exp=2", if0.event_count); end
    log_q.delete(); tcnt = 0;
    if0.play_start = 1; cyc(); if0.play_start = 0;
    ticks(7);
    total++; if (log_q.size() != 2) begin bad++; $display("FAIL same_tick_num got=%0d exp=2", log_q.size()); end
    else begin
      total++; if (log_q[0].m !== 5'b10010 || log_q[0].t != eq(5)) begin bad++; $display("FAIL same_tick_first got tick=%0d mask=%b exp tick=%0d mask=10010", log_q[0].t, log_q[0].m, eq(5)); end
      total++; if (log_q[1].m !== 5'b00001 || log_q[1].t != eq(5)) begin bad++; $display("FAIL same_tick_second got tick=%0d mask=%b exp tick=%0d mask=00001", log_q[1].t, log_q[1].m, eq(5)); end
      total++; if (log_q[1].c - log_q[0].c != 2) begin bad++; $display("FAIL same_tick_spacing got=%0d exp=2", log_q[1].c - log_q[0].c); end
    end
    if0.play_stop = 1; cyc(); if0.play_stop = 0;
  endtask

  task automatic test_overflow();
    if1.rec_start = 1; cyc(); if1.rec_start = 0;
    for (int i = 0; i < 6; i++) begin
      if1.hit = 5'b00001; cyc(); if1.hit = '0; cyc();
      if (i == 3) begin
        total++; if (if1.overflow !== 1'b0 || if1.event_count !== 3'd4) begin
          bad++; $display("FAIL ovf_at_full got ovf=%b cnt=%0d exp ovf=0 cnt=4", if1.overflow, if1.event_count);
        end
      end
    end
    total++; if (if1.event_count !== 3'd4) begin bad++; $display("FAIL ovf_count got=%0d exp=4", if1.event_count); end
    total++; if (if1.overflow !== 1'b1) begin bad++; $display("FAIL ovf_flag got=%b exp=1", if1.overflow); end
    if1.rec_stop = 1; cyc(); if1.rec_stop = 0;
    total++; if (if1.overflow !== 1'b1) begin bad++; $display("FAIL ovf_sticky got=%b exp=1", if1.overflow); end
    if1.rec_start = 1; cyc(); if1.rec_start = 0;
    total++; if (if1.overflow !== 1'b0 || if1.event_count !== 3'd0) begin
      bad++; $display("FAIL ovf_clear got ovf=%b cnt=%0d exp ovf=0 cnt=0", if1.overflow, if1.event_count);
    end
    if1.rec_stop = 1; cyc(); if1.rec_stop = 0;
  endtask

  task automatic test_reset_mid_play();
    rst_n = 0; cyc(); rst_n = 1; cyc();
    if0.play_start = 1; cyc(); if0.play_start = 0;
    total++; if (if0.play_active !== 1'b0) begin bad++; $display("FAIL play_no_loop got=%b exp=0", if0.play_active); end
    if0.rec_start = 1; cyc(); if0.rec_start = 0;
    if0.hit = 5'b00010; cyc(); if0.hit = '0;
    ticks(2);
    if0.rec_stop = 1; cyc(); if0.rec_stop = 0;
    if0.play_start = 1; cyc(); if0.play_start = 0;
    cyc(); cyc();
    total++; if (if0.play_hit !== 5'b00010) begin bad++; $display("FAIL ts0_event got=%b exp=00010", if0.play_hit); end
    #2; rst_n = 0; #1;
    total++; if (if0.play_hit !== 5'b0) begin bad++; $display("FAIL async_rst_play_hit got=%b exp=0", if0.play_hit); end
    total++; if (if0.play_active !== 1'b0) begin bad++; $display("FAIL async_rst_play_active got=%b exp=0", if0.play_active); end
    rst_n = 1;
    cyc();
    if0.play_start = 1; cyc(); if0.play_start = 0;
    total++; if (if0.play_active !== 1'b0) begin bad++; $display("FAIL loop_valid_cleared got=%b exp=0", if0.play_active); end
  endtask

  task automatic test_quant();
    if0.rec_start = 1; cyc(); if0.rec_start = 0;
    ticks(13);
    if0.hit = 5'b00001; cyc(); if0.hit = '0;
    ticks(2);
    if0.rec_stop = 1; cyc(); if0.rec_stop = 0;
    log_q.delete(); tcnt = 0;
    if0.play_start = 1; cyc(); if0.play_start = 0;
    ticks(16);
    total++; if (log_q.size() != 1) begin bad++; $display("FAIL quant_num got=%0d exp=1", log_q.size()); end
    else begin
      total++; if (log_q[0].t != eq(13)) begin bad++; $display("FAIL quant_tick got=%0d exp=%0d", log_q[0].t, eq(13)); end
    end
    if0.play_stop = 1; cyc(); if0.play_stop = 0;
  endtask

  initial begin
    test_reset();
    test_record();
    test_play();
    test_same_tick();
    test_overflow();
    test_reset_mid_play();
    test_quant();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
